// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-bit synchronizer plus stability counter, giving clean
// levels and one-cycle change/rise pulses. Optional rise latch under SW_EDGE_LATCH_EN.
module switch_debouncer #(
  parameter int N_SW            = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_SW-1:0] sw_raw,
`ifdef SW_EDGE_LATCH_EN
  input  logic [N_SW-1:0] edge_clr,
  output logic [N_SW-1:0] sw_edge_latched,
`endif
  output logic [N_SW-1:0] switches,
  output logic [N_SW-1:0] sw_changed,
  output logic [N_SW-1:0] sw_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]  sync_q [SYNC_STAGES];
  logic [N_SW-1:0]  s;
  logic [CNT_W-1:0] cnt [N_SW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Counter only runs while the synchronized level disagrees with the accepted one;
  // it is cleared on acceptance, so it can never pass CNT_LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
      switches   <= '0;
      sw_changed <= '0;
      sw_rise    <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        sw_changed[i] <= 1'b0;
        sw_rise[i]    <= 1'b0;
        if (s[i] == switches[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          switches[i]   <= s[i];
          cnt[i]        <= '0;
          sw_changed[i] <= 1'b1;
          sw_rise[i]    <= s[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef SW_EDGE_LATCH_EN
  // Set wins over clear when both land in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sw_edge_latched <= '0;
    else          sw_edge_latched <= (sw_edge_latched & ~edge_clr) | sw_rise;
  end
`endif

endmodule
